// File: rtl/cpu_pkg.sv
// Shared CPU types and widths for the PC sequencer, instruction ROM and decode.
package cpu_pkg;

    localparam int unsigned PC_W  = 10;
    localparam int unsigned OFF_W = 8;

    typedef logic [PC_W-1:0]  pc_t;
    typedef logic [OFF_W-1:0] off_t;

    typedef enum logic [1:0] {IDLE, RUN, DONE} seq_state_t;

    // Relative branch offsets are two's complement; widen to the pc width.
    function automatic pc_t sext_off(input off_t o);
        return {{(PC_W - OFF_W){o[OFF_W-1]}}, o};
    endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/status bundle between the sequencer and the run-control / decode side.
interface pc_sequencer_if
    import cpu_pkg::*;
#(
    parameter int unsigned CNT_W = 16
);

    logic             start;
    logic             stall;
    logic             halt;
    logic             branch_en;
    logic             branch_abs;
    pc_t              target;
    off_t             offset;
    pc_t              pc;
    logic             run;
    logic             done;
    logic [CNT_W-1:0] instr_cnt;

    modport master (
        output start, stall, halt, branch_en, branch_abs, target, offset,
        input  pc, run, done, instr_cnt
    );

    modport slave (
        input  start, stall, halt, branch_en, branch_abs, target, offset,
        output pc, run, done, instr_cnt
    );

endinterface

// File: rtl/pc_sequencer_pc_next_calc.sv
// Next program counter for a running core: hold, absolute, relative or sequential step.
module pc_next_calc
    import cpu_pkg::*;
(
    input  pc_t  pc,
    input  logic stall,
    input  logic halt,
    input  logic branch_en,
    input  logic branch_abs,
    input  pc_t  target,
    input  off_t offset,
    output pc_t  pc_next
);

    // Additions are PC_W wide, so wrap-around modulo 2^PC_W falls out naturally.
    always_comb begin
        pc_next = pc + pc_t'(1);
        if (stall || halt) begin
            pc_next = pc;
        end else if (branch_en) begin
            pc_next = branch_abs ? target : pc + sext_off(offset);
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Run-control FSM, program counter register and saturating retired-instruction counter.
module pc_sequencer
    import cpu_pkg::*;
#(
    parameter pc_t         RESET_PC   = '0,
    parameter bit          AUTO_START = 1'b1,
    parameter int unsigned CNT_W      = 16
) (
    input logic           clk,
    input logic           reset,
    pc_sequencer_if.slave bus
);

    seq_state_t       state_q, state_d;
    pc_t              pc_q, pc_d;
    pc_t              pc_next;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    pc_next_calc u_pc_next_calc (
        .pc         (pc_q),
        .stall      (bus.stall),
        .halt       (bus.halt),
        .branch_en  (bus.branch_en),
        .branch_abs (bus.branch_abs),
        .target     (bus.target),
        .offset     (bus.offset),
        .pc_next    (pc_next)
    );

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start || AUTO_START) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                if (bus.start) begin
                    pc_d  = RESET_PC;
                    cnt_d = '0;
                end else begin
                    pc_d = pc_next;
                    // A stalled cycle retires nothing, even if halt is presented.
                    if (!bus.stall) begin
                        cnt_d = cnt_inc;
                        if (bus.halt) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = RESET_PC;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                pc_d    = RESET_PC;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.pc        = pc_q;
    assign bus.run       = (state_q == RUN);
    assign bus.done      = (state_q == DONE);
    assign bus.instr_cnt = cnt_q;

endmodule
